// File: rtl/zybo_btn_debounce.sv
// Four-channel push-button conditioner: 2-FF sync, debounce window,
// hold counter, and single-cycle press/release/long-press pulses.
module zybo_btn_debounce #(
    parameter logic [20:0] DEBOUNCE_CNT = 21'd1249999,
    parameter logic [26:0] LONG_CNT     = 27'd124999999
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] BTN,
    output logic [3:0] BTN_LEVEL,
    output logic [3:0] BTN_PRESS,
    output logic [3:0] BTN_RELEASE,
    output logic [3:0] BTN_LONG
);

    logic [3:0]  sync1_q, sync2_q;
    logic [3:0]  level_q, level_d;
    logic [3:0]  press_q, press_d;
    logic [3:0]  release_q, release_d;
    logic [3:0]  long_q, long_d;
    logic [20:0] dcnt_q [4];
    logic [20:0] dcnt_d [4];
    logic [26:0] hcnt_q [4];
    logic [26:0] hcnt_d [4];

    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        for (int i = 0; i < 4; i++) begin
            dcnt_d[i] = '0;
            hcnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (dcnt_q[i] == DEBOUNCE_CNT) begin
                    level_d[i]   = sync2_q[i];
                    press_d[i]   = sync2_q[i];
                    release_d[i] = ~sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 21'd1;
                end
            end
            // Hold counter saturates at LONG_CNT so the pulse fires once per press
            if (level_q[i]) begin
                if (hcnt_q[i] != LONG_CNT) begin
                    hcnt_d[i] = hcnt_q[i] + 27'd1;
                    long_d[i] = (hcnt_q[i] == LONG_CNT - 27'd1);
                end else begin
                    hcnt_d[i] = hcnt_q[i];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            dcnt_q    <= '{default: '0};
            hcnt_q    <= '{default: '0};
        end else begin
            sync1_q   <= BTN;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
        end
    end

    assign BTN_LEVEL   = level_q;
    assign BTN_PRESS   = press_q;
    assign BTN_RELEASE = release_q;
    assign BTN_LONG    = long_q;

endmodule

// File: tb/tb_zybo_btn_debounce.sv
// Scoreboard bench for zybo_btn_debounce with short debounce/hold windows.
module tb_zybo_btn_debounce;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [3:0] BTN = 4'hF;
    logic [3:0] BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG;

    typedef struct {
        int       cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
        logic [3:0] lvl;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    zybo_btn_debounce #(
        .DEBOUNCE_CNT(21'd9),
        .LONG_CNT(27'd20)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .BTN(BTN),
        .BTN_LEVEL(BTN_LEVEL),
        .BTN_PRESS(BTN_PRESS),
        .BTN_RELEASE(BTN_RELEASE),
        .BTN_LONG(BTN_LONG)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic wait_edges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push(input int c, input logic [3:0] p, input logic [3:0] r,
                        input logic [3:0] l, input logic [3:0] v);
        exp_t e;
        e.cyc = c; e.press = p; e.rel = r; e.lng = l; e.lvl = v;
        q.push_back(e);
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if ({BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG} != 16'h0) begin
            n_fail++;
            $display("FAIL %s: got lvl=%h prs=%h rel=%h lng=%h want all 0",
                     name, BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_LONG);
        end
    endtask

    // Monitor: every pulse must match the oldest expected event
    always @(negedge CLK) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_event: no pulse by edge %0d, want prs=%h rel=%h lng=%h",
                     e.cyc, e.press, e.rel, e.lng);
        end
        if ((BTN_PRESS | BTN_RELEASE | BTN_LONG) != 4'h0) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: edge %0d prs=%h rel=%h lng=%h want none",
                         cyc, BTN_PRESS, BTN_RELEASE, BTN_LONG);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.press != BTN_PRESS || e.rel != BTN_RELEASE ||
                    e.lng != BTN_LONG || e.lvl != BTN_LEVEL) begin
                    n_fail++;
                    $display("FAIL event: got edge %0d prs=%h rel=%h lng=%h lvl=%h want edge %0d prs=%h rel=%h lng=%h lvl=%h",
                             cyc, BTN_PRESS, BTN_RELEASE, BTN_LONG, BTN_LEVEL,
                             e.cyc, e.press, e.rel, e.lng, e.lvl);
                end
            end
        end
    end

    initial begin
        int c;
        // Reset with all buttons held, then release: held buttons count as a new press
        wait_edges(3);
        check_zero("reset_hold");
        RST_N = 1'b1;
        c = cyc;
        push(c + 12, 4'hF, 4'h0, 4'h0, 4'hF);
        wait_edges(14);
        BTN = 4'h0;
        c = cyc;
        push(c + 12, 4'h0, 4'hF, 4'h0, 4'h0);
        wait_edges(16);

        // Clean press/release on channel 0
        BTN[0] = 1'b1;
        c = cyc;
        push(c + 12, 4'h1, 4'h0, 4'h0, 4'h1);
        wait_edges(14);
        BTN[0] = 1'b0;
        c = cyc;
        push(c + 12, 4'h0, 4'h1, 4'h0, 4'h0);
        wait_edges(16);

        // Bouncing channel 1, 5-cycle runs, then steady high
        for (int k = 0; k < 4; k++) begin
            BTN[1] = (k % 2 == 0);
            wait_edges(5);
        end
        BTN[1] = 1'b1;
        c = cyc;
        push(c + 12, 4'h2, 4'h0, 4'h0, 4'h2);
        wait_edges(14);
        BTN[1] = 1'b0;
        c = cyc;
        push(c + 12, 4'h0, 4'h2, 4'h0, 4'h0);
        wait_edges(16);

        // Long press on channel 2: single long pulse, then 100 quiet cycles
        BTN[2] = 1'b1;
        c = cyc;
        push(c + 12, 4'h4, 4'h0, 4'h0, 4'h4);
        push(c + 32, 4'h0, 4'h0, 4'h4, 4'h4);
        wait_edges(132);
        BTN[2] = 1'b0;
        c = cyc;
        push(c + 12, 4'h0, 4'h4, 4'h0, 4'h0);
        wait_edges(16);

        // Short press on channel 3: debounced level stays up fewer than 20 edges
        BTN[3] = 1'b1;
        c = cyc;
        push(c + 12, 4'h8, 4'h0, 4'h0, 4'h8);
        wait_edges(15);
        BTN[3] = 1'b0;
        push(c + 27, 4'h0, 4'h8, 4'h0, 4'h0);
        wait_edges(16);

        // Reset mid-window on channel 0 while channel 3 is debounced high
        BTN[3] = 1'b1;
        c = cyc;
        push(c + 12, 4'h8, 4'h0, 4'h0, 4'h8);
        wait_edges(14);
        BTN[0] = 1'b1;
        wait_edges(6);
        #1;
        RST_N = 1'b0;
        #1;
        check_zero("async_reset");
        wait_edges(3);
        check_zero("reset_mid");
        RST_N = 1'b1;
        c = cyc;
        push(c + 12, 4'h9, 4'h0, 4'h0, 4'h9);
        wait_edges(14);
        BTN = 4'h0;
        c = cyc;
        push(c + 12, 4'h0, 4'h9, 4'h0, 4'h0);
        wait_edges(16);

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL leftover_event: edge %0d never seen, want prs=%h rel=%h lng=%h",
                     e.cyc, e.press, e.rel, e.lng);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
